// File: rtl/norm_share_sched.sv
// norm_share_sched: one post-add normalizer shared round-robin between NUM_REQ
// vector ALU lanes. The granted operand is captured, then normalized either
// iteratively (one left shift per SHIFT cycle) or, when NORM_SHARE_LZC_FAST_EN
// is defined, in a single EVAL cycle using a leading-zero count. Results leave
// on a valid/ready port tagged with the lane id.
//
// Optional build macro: NORM_SHARE_LZC_FAST_EN (single-cycle normalization).
module norm_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int SIG_W   = 24,
  parameter int EXP_W   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*SIG_W-1:0] req_sig,
  input  logic [NUM_REQ*EXP_W-1:0] req_exp,
  input  logic [NUM_REQ-1:0]       req_cout,
  input  logic [NUM_REQ-1:0]       req_neg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIG_W-1:0]         out_sig,
  output logic [EXP_W-1:0]         out_exp,
  output logic                     out_sign_flip,
  output logic                     out_zero,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy
);

`ifdef NORM_SHARE_LZC_FAST_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd3
  } state_t;

  localparam int LZC_W = $clog2(SIG_W + 1);

  // Leading-zero count of a significand; SIG_W for an all-zero input.
  function automatic logic [LZC_W-1:0] lzc(input logic [SIG_W-1:0] v);
    logic [LZC_W-1:0] cnt;
    logic             seen;
    cnt  = '0;
    seen = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!seen && !v[i]) begin
        cnt = cnt + LZC_W'(1);
      end else begin
        seen = 1'b1;
      end
    end
    return cnt;
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              cout_q, cout_d;
  logic              neg_q, neg_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              out_valid_q, out_valid_d;
  logic [SIG_W-1:0]  out_sig_q, out_sig_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic              out_flip_q, out_flip_d;
  logic              out_zero_q, out_zero_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;

  logic              grant_found_s;
  logic [ID_W-1:0]   grant_s;
  logic [ID_W:0]     idx_w_s;
  logic [ID_W-1:0]   idx_s;
  logic [ID_W:0]     ptr_inc_s;

  logic [SIG_W-1:0]  res_sig_s;
  logic [EXP_W-1:0]  res_exp_s;
  logic              res_flip_s;
  logic              res_zero_s;
  logic              finish_s;
`ifdef NORM_SHARE_LZC_FAST_EN
  logic [LZC_W-1:0]  lz_s;
  logic [EXP_W-1:0]  lim_s;
  logic [31:0]       shamt_s;
`endif

  // Round-robin search: first valid lane at or after rr_ptr, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = '0;
    idx_w_s       = '0;
    idx_s         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx_w_s >= (ID_W+1)'(NUM_REQ)) begin
        idx_w_s = idx_w_s - (ID_W+1)'(NUM_REQ);
      end else begin
        idx_w_s = idx_w_s;
      end
      idx_s = idx_w_s[ID_W-1:0];
      if (!grant_found_s && req_valid[idx_s]) begin
        grant_found_s = 1'b1;
        grant_s       = idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Pointer advances to the lane after the one just granted.
  always_comb begin
    ptr_inc_s = {1'b0, grant_s} + (ID_W+1)'(1);
    if (ptr_inc_s >= (ID_W+1)'(NUM_REQ)) begin
      ptr_inc_s = ptr_inc_s - (ID_W+1)'(NUM_REQ);
    end else begin
      ptr_inc_s = ptr_inc_s;
    end
  end

  // Accept is offered only in IDLE and is forced low while reset is applied.
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && !rst && grant_found_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state, operand capture and result evaluation.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sig_d       = sig_q;
    exp_d       = exp_q;
    cout_d      = cout_q;
    neg_d       = neg_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_sig_d   = out_sig_q;
    out_exp_d   = out_exp_q;
    out_flip_d  = out_flip_q;
    out_zero_d  = out_zero_q;
    out_id_d    = out_id_q;
    res_sig_s   = sig_q;
    res_exp_s   = exp_q;
    res_flip_s  = 1'b0;
    res_zero_s  = 1'b0;
    finish_s    = 1'b0;
`ifdef NORM_SHARE_LZC_FAST_EN
    lz_s        = lzc(sig_q);
    lim_s       = exp_q - EXP_W'(1);
    shamt_s     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          sig_d    = req_sig[int'(grant_s)*SIG_W +: SIG_W];
          exp_d    = req_exp[int'(grant_s)*EXP_W +: EXP_W];
          cout_d   = req_cout[grant_s];
          neg_d    = req_neg[grant_s];
          id_d     = grant_s;
          rr_ptr_d = ptr_inc_s[ID_W-1:0];
          state_d  = S_EVAL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EVAL: begin
        case ({neg_q, cout_q})
          2'b01: begin
            // Carry out of an addition: one right shift; exponent may wrap.
            res_sig_s = {1'b1, sig_q[SIG_W-1:1]};
            res_exp_s = exp_q + EXP_W'(1);
            finish_s  = 1'b1;
          end
          2'b00: begin
            finish_s = 1'b1;
          end
          2'b10: begin
            // Subtraction borrowed: magnitude is the two's complement.
            res_sig_s  = ~sig_q + SIG_W'(1);
            res_flip_s = 1'b1;
            finish_s   = 1'b1;
          end
          2'b11: begin
            if (sig_q == '0) begin
              res_sig_s  = '0;
              res_exp_s  = '0;
              res_zero_s = 1'b1;
              finish_s   = 1'b1;
            end else if (sig_q[SIG_W-1]) begin
              finish_s = 1'b1;
            end else if (exp_q <= EXP_W'(1)) begin
              // Already at the underflow clamp: no shifting allowed.
              finish_s = 1'b1;
            end else begin
`ifdef NORM_SHARE_LZC_FAST_EN
              if (32'(lz_s) < 32'(lim_s)) begin
                shamt_s = 32'(lz_s);
              end else begin
                shamt_s = 32'(lim_s);
              end
              res_sig_s = sig_q << shamt_s;
              res_exp_s = exp_q - EXP_W'(shamt_s);
              finish_s  = 1'b1;
`else
              state_d = S_SHIFT;
`endif
            end
          end
          default: begin
            finish_s = 1'b1;
          end
        endcase
      end
`ifndef NORM_SHARE_LZC_FAST_EN
      S_SHIFT: begin
        res_sig_s = {sig_q[SIG_W-2:0], 1'b0};
        res_exp_s = exp_q - EXP_W'(1);
        sig_d     = res_sig_s;
        exp_d     = res_exp_s;
        if (res_sig_s[SIG_W-1] || (res_exp_s == EXP_W'(1))) begin
          finish_s = 1'b1;
        end else begin
          state_d = S_SHIFT;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (finish_s) begin
      state_d     = S_DONE;
      out_valid_d = 1'b1;
      out_sig_d   = res_sig_s;
      out_exp_d   = res_exp_s;
      out_flip_d  = res_flip_s;
      out_zero_d  = res_zero_s;
      out_id_d    = id_q;
    end else begin
      out_valid_d = out_valid_d;
    end
  end

  // State, working operand and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      sig_q       <= '0;
      exp_q       <= '0;
      cout_q      <= 1'b0;
      neg_q       <= 1'b0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_sig_q   <= '0;
      out_exp_q   <= '0;
      out_flip_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sig_q       <= sig_d;
      exp_q       <= exp_d;
      cout_q      <= cout_d;
      neg_q       <= neg_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_sig_q   <= out_sig_d;
      out_exp_q   <= out_exp_d;
      out_flip_q  <= out_flip_d;
      out_zero_q  <= out_zero_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_sig       = out_sig_q;
  assign out_exp       = out_exp_q;
  assign out_sign_flip = out_flip_q;
  assign out_zero      = out_zero_q;
  assign out_id        = out_id_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_norm_share_sched.sv
// Scoreboard bench for norm_share_sched: directed operands push expected
// results; a monitor compares whenever out_valid is presented.
module tb_norm_share_sched;
  localparam int NUM_REQ = 4;
  localparam int SIG_W   = 24;
  localparam int EXP_W   = 8;
  localparam int ID_W    = 2;
`ifdef NORM_SHARE_LZC_FAST_EN
  localparam int SH = 0;
`else
  localparam int SH = 1;
`endif

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*SIG_W-1:0] req_sig;
  logic [NUM_REQ*EXP_W-1:0] req_exp;
  logic [NUM_REQ-1:0]       req_cout;
  logic [NUM_REQ-1:0]       req_neg;
  logic                     out_valid;
  logic                     out_ready;
  logic [SIG_W-1:0]         out_sig;
  logic [EXP_W-1:0]         out_exp;
  logic                     out_sign_flip;
  logic                     out_zero;
  logic [ID_W-1:0]          out_id;
  logic                     busy;

  norm_share_sched #(.NUM_REQ(NUM_REQ), .SIG_W(SIG_W), .EXP_W(EXP_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sig(req_sig), .req_exp(req_exp), .req_cout(req_cout), .req_neg(req_neg),
    .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig), .out_exp(out_exp),
    .out_sign_flip(out_sign_flip), .out_zero(out_zero), .out_id(out_id), .busy(busy)
  );

  typedef struct {
    logic [SIG_W-1:0] sig;
    logic [EXP_W-1:0] exp;
    logic             flip;
    logic             zero;
    logic [ID_W-1:0]  id;
    int               lat;
  } exp_t;

  exp_t sb_q[$];
  int   gcyc_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_grants = 0;
  bit   showing  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Grant logger: records the cycle in which each handshake is offered.
  always @(negedge clk) begin
    if (!rst && ((req_valid & req_ready) != '0)) begin
      n_grants++;
      gcyc_q.push_back(cyc);
      chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
    end
  end

  // Monitor: compare every presented output cycle against the queue head.
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (rst) begin
      showing = 1'b0;
    end else if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        e = sb_q[0];
        if (!showing) begin
          showing = 1'b1;
          if (gcyc_q.size() == 0) begin
            chk("grant_logged", 32'd0, 32'd1);
          end else begin
            g = gcyc_q.pop_front();
            chk("latency", 32'(cyc - g), 32'(e.lat));
          end
        end
        chk("out_sig", 32'(out_sig), 32'(e.sig));
        chk("out_exp", 32'(out_exp), 32'(e.exp));
        chk("out_sign_flip", 32'(out_sign_flip), 32'(e.flip));
        chk("out_zero", 32'(out_zero), 32'(e.zero));
        chk("out_id", 32'(out_id), 32'(e.id));
        chk("busy_in_done", 32'(busy), 32'd1);
        if (out_ready) begin
          void'(sb_q.pop_front());
          showing = 1'b0;
        end
      end
    end
  end

  task automatic push(input int lane, input logic [SIG_W-1:0] s, input logic [EXP_W-1:0] e,
                      input logic f, input logic z, input int lat);
    exp_t x;
    x.sig = s; x.exp = e; x.flip = f; x.zero = z; x.id = ID_W'(lane); x.lat = lat;
    sb_q.push_back(x);
  endtask

  task automatic drive(input int lane, input logic [SIG_W-1:0] s, input logic [EXP_W-1:0] e,
                       input logic c, input logic n);
    req_sig[lane*SIG_W +: SIG_W] = s;
    req_exp[lane*EXP_W +: EXP_W] = e;
    req_cout[lane] = c;
    req_neg[lane]  = n;
    req_valid[lane] = 1'b1;
  endtask

  task automatic wait_grant(input int lane);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[lane]) ok = 1'b1;
    end
    chk($sformatf("grant_lane%0d", lane), 32'(ok), 32'd1);
    @(posedge clk); #2;
    req_valid[lane] = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) ok = 1'b1;
    end
    chk("drain", 32'(ok), 32'd1);
  endtask

  task automatic send(input int lane, input logic [SIG_W-1:0] s, input logic [EXP_W-1:0] e,
                      input logic c, input logic n, input logic [SIG_W-1:0] es,
                      input logic [EXP_W-1:0] ee, input logic ef, input logic ez, input int k);
    @(posedge clk); #2;
    push(lane, es, ee, ef, ez, 2 + k * SH);
    drive(lane, s, e, c, n);
    wait_grant(lane);
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    int  base;
    int  ng;
    bit  ok;
    rst = 1'b0; req_valid = '0; req_sig = '0; req_exp = '0; req_cout = '0; req_neg = '0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_sig", 32'(out_sig), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // lane, sig, exp, cout, neg -> expected sig, exp, flip, zero, shifts
    send(2, 24'h800000, 8'h7F, 1'b1, 1'b0, 24'hC00000, 8'h80, 1'b0, 1'b0, 0);
    send(0, 24'h000F00, 8'h90, 1'b1, 1'b1, 24'hF00000, 8'h84, 1'b0, 1'b0, 12);
    send(1, 24'h000001, 8'h55, 1'b0, 1'b1, 24'hFFFFFF, 8'h55, 1'b1, 1'b0, 0);
    send(3, 24'h000000, 8'h77, 1'b1, 1'b1, 24'h000000, 8'h00, 1'b0, 1'b1, 0);
    send(1, 24'hFFFFFF, 8'hFF, 1'b1, 1'b0, 24'hFFFFFF, 8'h00, 1'b0, 1'b0, 0);
    send(2, 24'h000F00, 8'h05, 1'b1, 1'b1, 24'h00F000, 8'h01, 1'b0, 1'b0, 4);
    send(0, 24'h812345, 8'h40, 1'b1, 1'b1, 24'h812345, 8'h40, 1'b0, 1'b0, 0);
    send(1, 24'h000001, 8'h30, 1'b1, 1'b1, 24'h800000, 8'h19, 1'b0, 1'b0, 23);
    send(3, 24'h123456, 8'h33, 1'b0, 1'b0, 24'h123456, 8'h33, 1'b0, 1'b0, 0);

    // All lanes requesting continuously: expect grants 0,1,2,3,0.
    @(posedge clk); #2;
    push(0, 24'hA00000, 8'h10, 1'b0, 1'b0, 2);
    push(1, 24'hA00001, 8'h11, 1'b0, 1'b0, 2);
    push(2, 24'hA00002, 8'h12, 1'b0, 1'b0, 2);
    push(3, 24'hA00003, 8'h13, 1'b0, 1'b0, 2);
    push(0, 24'hA00000, 8'h10, 1'b0, 1'b0, 2);
    for (int l = 0; l < NUM_REQ; l++) drive(l, 24'hA00000 | 24'(l), 8'h10 + 8'(l), 1'b0, 1'b0);
    base = n_grants;
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (n_grants >= base + 5) ok = 1'b1;
    end
    chk("five_grants", 32'(ok), 32'd1);
    @(posedge clk); #2;
    req_valid = '0;
    wait_drain();

    // Consumer stalls for 5 cycles: output held, no new grant.
    @(posedge clk); #2;
    out_ready = 1'b0;
    push(1, 24'h654321, 8'h22, 1'b0, 1'b0, 2);
    drive(1, 24'h654321, 8'h22, 1'b0, 1'b0);
    wait_grant(1);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    chk("stall_valid_seen", 32'(ok), 32'd1);
    ng = n_grants;
    @(posedge clk); #2;
    push(3, 24'h0ABCDE, 8'h44, 1'b0, 1'b0, 2);
    drive(3, 24'h0ABCDE, 8'h44, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("stall_no_ready", 32'(req_ready), 32'd0);
      chk("stall_valid_held", 32'(out_valid), 32'd1);
    end
    chk("stall_no_grant", 32'(n_grants), 32'(ng));
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_grant(3);
    wait_drain();

    // Reset during SHIFT: everything clears, lane 0 wins first afterwards.
    @(posedge clk); #2;
    drive(0, 24'h000F00, 8'h90, 1'b1, 1'b1);
    wait_grant(0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    sb_q.delete();
    gcyc_q.delete();
    drive(0, 24'h111111, 8'h11, 1'b0, 1'b0);
    drive(1, 24'h222222, 8'h22, 1'b0, 1'b0);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_sig", 32'(out_sig), 32'd0);
    chk("mid_rst_out_exp", 32'(out_exp), 32'd0);
    chk("mid_rst_out_id", 32'(out_id), 32'd0);
    chk("mid_rst_flags", 32'({out_sign_flip, out_zero}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #2;
    push(0, 24'h111111, 8'h11, 1'b0, 1'b0, 2);
    push(1, 24'h222222, 8'h22, 1'b0, 1'b0, 2);
    rst = 1'b0;
    wait_grant(0);
    wait_grant(1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/norm_share_sched.md
Name: norm_share_sched

Overview:
- Shares one iterative post-add normalizer between NUM_REQ Vector ALU lanes.
- Round-robin arbitration across lanes; the granted operand is captured into internal registers.
- Normalization is sequenced over multiple cycles: one left-shift per cycle for cancellation results.
- Each result is returned on a valid/ready output port, tagged with the originating lane id.

Parameters:
- NUM_REQ, 4, number of requesting lanes (≥2).
- SIG_W, 24, significand width (hidden bit at MSB).
- EXP_W, 8, exponent width.
- ID_W, 2, lane-id width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-lane request valid.
- req_ready  out  NUM_REQ  per-lane accept, one-hot or zero.
- req_sig  in  NUM_REQ*SIG_W  lane i's significand in bits [i*SIG_W +: SIG_W].
- req_exp  in  NUM_REQ*EXP_W  lane i's pre-normalization exponent.
- req_cout  in  NUM_REQ  adder carry-out per lane.
- req_neg  in  NUM_REQ  effective-subtraction flag per lane.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_sig  out  SIG_W  normalized significand.
- out_exp  out  EXP_W  normalized exponent.
- out_sign_flip  out  1  result was two's-complemented (sign must invert).
- out_zero  out  1  exact-zero result.
- out_id  out  ID_W  originating lane.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, all out_* =0, req_ready=0, busy=0.
- FSM states: IDLE, EVAL, SHIFT, DONE.
- IDLE:
  - req_ready is combinational: one-hot at the first lane with req_valid=1, searching from rr_ptr upward with wrap.
  - On a handshake, capture sig/exp/cout/neg and the lane id; set rr_ptr=(grant+1) mod NUM_REQ; next state EVAL.
  - Lanes not granted hold their request; the block never drops a held request.
- EVAL (1 cycle), by case:
  - neg=0, cout=1: sig={1'b1,sig[SIG_W-1:1]}, exp=exp+1 → DONE.
  - neg=0, cout=0: pass-through → DONE.
  - neg=1, cout=0: sig=~sig+1, exp unchanged, sign_flip=1 → DONE.
  - neg=1, cout=1 and sig==0: out_zero=1, sig=0, exp=0 → DONE.
  - neg=1, cout=1 and sig[MSB]=1 → DONE unchanged.
  - Otherwise (neg=1, cout=1, nonzero, MSB=0) → SHIFT.
- SHIFT: each cycle sig<<=1 and exp-=1.
  - Exit to DONE when the new sig[MSB]=1, or when exp reaches 1 (underflow clamp: stop shifting, exp held at 1).
  - exp never wraps below 1 in SHIFT.
  - Maximum SHIFT cycles: SIG_W-1.
- neg=0, cout=1 with exp=all-ones: exp wraps to 0 modulo 2^EXP_W; overflow handling belongs to the downstream rounder.
- DONE:
  - out_valid=1, and out_* hold stable until out_ready=1.
  - On the handshake: out_valid=0 next cycle, state=IDLE.
  - No new grant in the cycle of the output handshake; next grant is earliest the following cycle.
- Latency, grant to out_valid: 2 cycles, plus k cycles for k shifts.
- out_* retain their last value outside DONE; only out_valid qualifies them.
- rst asserted mid-operation: immediate return to reset values; the in-flight op is discarded and rr_ptr=0.

Optional Feature:
- Macro: NORM_SHARE_LZC_FAST_EN.
- Defined: SHIFT state is removed. EVAL computes the leading-zero count combinationally (clamped so exp≥1) and applies the full shift in one cycle, giving a fixed 2-cycle latency.
- Undefined: iterative SHIFT as above.
- Final out_sig/out_exp/out_zero/out_sign_flip are identical in both builds.

Test Plan:
- Lane 2 alone, sig=0x800000, exp=0x7F, cout=1, neg=0 → out_sig=0xC00000, out_exp=0x80, out_id=2, out_valid 2 cycles after grant.
- Lane 0, neg=1, cout=1, sig=0x000F00, exp=0x90 → 12 SHIFT cycles, out_sig=0xF00000, out_exp=0x84 (fast build: 2-cycle latency, same values).
- Lane 1, neg=1, cout=0, sig=0x000001 → out_sig=0xFFFFFF, out_sign_flip=1, out_exp unchanged.
- Lane 3, neg=1, cout=1, sig=0 → out_zero=1, out_sig=0, out_exp=0, no SHIFT cycles.
- All 4 lanes hold valid continuously, out_ready=1 → grant order 0,1,2,3,0; with out_ready=0 for 5 cycles, outputs held stable and no new grant.
- rst pulsed during SHIFT → all outputs 0 at once; after release, lane 0 is granted first.
